// File: rtl/instr_seq_ctrl.sv
// Purpose : multi-cycle RV32 R-type sequencer (IDLE->IF->ID->RR->EX->WB) driving a
//           register array / ALU datapath through one-cycle strobes.
// Latency : 5 cycles per legal instruction (fetch returning in its first IF cycle);
//           an illegal instruction costs IF+ID only.
// Backpressure : IF waits as long as needed for inst_valid; inst_valid outside IF is ignored.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   run                 level; keeps the sequencer fetching back-to-back
//   inst_req/inst_addr  fetch request and address (= PC) to instruction memory
//   inst_valid/inst_data fetch return
//   R_Addr_A/R_Addr_B/W_Addr/ALU_OP  decoded fields, stable from ID until the next ID
//   rr_en/f_en/wb_en    operand latch / result latch / write-back strobes
//   Reg_Write           register write enable (WB only, suppressed for rd = x0)
//   illegal             one-cycle pulse after decoding an unsupported instruction
//   busy                high whenever the sequencer is not IDLE
//   instr_cnt           retired-instruction counter (wraps)
module instr_seq_ctrl #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  output logic            inst_req,
  output logic [PC_W-1:0] inst_addr,
  input  logic            inst_valid,
  input  logic [31:0]     inst_data,
  output logic [4:0]      R_Addr_A,
  output logic [4:0]      R_Addr_B,
  output logic [4:0]      W_Addr,
  output logic [3:0]      ALU_OP,
  output logic            Reg_Write,
  output logic            rr_en,
  output logic            f_en,
  output logic            wb_en,
  output logic            illegal,
  output logic            busy,
  output logic [15:0]     instr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IF,
    S_ID,
    S_RR,
    S_EX,
    S_WB
  } state_t;

  state_t          state;
  logic [31:0]     ir;
  logic [PC_W-1:0] pc;
  logic            ir_legal;

  // Decoded fields are direct slices of the instruction register, so they are
  // flop outputs that change only when a new word is captured on entry to ID.
  assign R_Addr_A  = ir[19:15];
  assign R_Addr_B  = ir[24:20];
  assign W_Addr    = ir[11:7];
  assign ALU_OP    = {ir[30], ir[14:12]};
  assign inst_addr = pc;

  // Only the base R-type ALU group: funct7 must be 0000000, or 0100000 for SUB/SRA.
  always_comb begin
    ir_legal = (ir[6:0] == 7'b0110011) && !ir[31] && (ir[29:25] == 5'b00000) &&
               (!ir[30] || (ir[14:12] == 3'b000) || (ir[14:12] == 3'b101));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      ir        <= '0;
      instr_cnt <= '0;
      inst_req  <= 1'b0;
      Reg_Write <= 1'b0;
      rr_en     <= 1'b0;
      f_en      <= 1'b0;
      wb_en     <= 1'b0;
      illegal   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // Strobes default low so each is asserted for exactly one state.
      rr_en     <= 1'b0;
      f_en      <= 1'b0;
      wb_en     <= 1'b0;
      Reg_Write <= 1'b0;
      illegal   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (run) begin
            state    <= S_IF;
            inst_req <= 1'b1;
            busy     <= 1'b1;
          end
        end

        S_IF: begin
          if (inst_valid) begin
            ir       <= inst_data;
            inst_req <= 1'b0;
            state    <= S_ID;
          end
        end

        S_ID: begin
          if (ir_legal) begin
            rr_en <= 1'b1;
            state <= S_RR;
          end else begin
            // Skip the instruction: no datapath strobes, no retirement.
            illegal <= 1'b1;
            pc      <= pc + PC_W'(4);
            if (run) begin
              state    <= S_IF;
              inst_req <= 1'b1;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
        end

        S_RR: begin
          f_en  <= 1'b1;
          state <= S_EX;
        end

        S_EX: begin
          wb_en     <= 1'b1;
          Reg_Write <= (ir[11:7] != 5'd0);  // x0 is never written
          state     <= S_WB;
        end

        S_WB: begin
          pc        <= pc + PC_W'(4);
          instr_cnt <= instr_cnt + 16'd1;
          // run is sampled only here, so dropping it mid-instruction lets it retire.
          if (run) begin
            state    <= S_IF;
            inst_req <= 1'b1;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state    <= S_IDLE;
          inst_req <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Purpose : self-checking bench for instr_seq_ctrl; directed instruction vectors with
//           hand-decoded expectations queued at issue time and checked by a monitor.
// Latency : monitor checks write-back (4 cycles after fetch) and illegal pulse (2 cycles).
// Backpressure : bench acts as instruction memory, optionally delaying inst_valid.
module tb_instr_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        inst_req;
  logic [7:0]  inst_addr;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [4:0]  R_Addr_A;
  logic [4:0]  R_Addr_B;
  logic [4:0]  W_Addr;
  logic [3:0]  ALU_OP;
  logic        Reg_Write;
  logic        rr_en;
  logic        f_en;
  logic        wb_en;
  logic        illegal;
  logic        busy;
  logic [15:0] instr_cnt;

  instr_seq_ctrl #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .inst_req   (inst_req),
    .inst_addr  (inst_addr),
    .inst_valid (inst_valid),
    .inst_data  (inst_data),
    .R_Addr_A   (R_Addr_A),
    .R_Addr_B   (R_Addr_B),
    .W_Addr     (W_Addr),
    .ALU_OP     (ALU_OP),
    .Reg_Write  (Reg_Write),
    .rr_en      (rr_en),
    .f_en       (f_en),
    .wb_en      (wb_en),
    .illegal    (illegal),
    .busy       (busy),
    .instr_cnt  (instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-decoded instruction table.
  typedef struct {
    logic [31:0] data;
    bit          legal;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  wa;
    logic [3:0]  op;
    bit          rw;
  } vec_t;

  vec_t vec [9];
  initial begin
    vec[0] = '{32'h002081B3, 1'b1, 5'd1, 5'd2, 5'd3, 4'h0, 1'b1};  // add x3,x1,x2
    vec[1] = '{32'h407302B3, 1'b1, 5'd6, 5'd7, 5'd5, 4'h8, 1'b1};  // sub x5,x6,x7
    vec[2] = '{32'h00208033, 1'b1, 5'd1, 5'd2, 5'd0, 4'h0, 1'b0};  // add x0,x1,x2
    vec[3] = '{32'h00000013, 1'b0, 5'd0, 5'd0, 5'd0, 4'h0, 1'b0};  // addi (I-type)
    vec[4] = '{32'h4020D1B3, 1'b1, 5'd1, 5'd2, 5'd3, 4'hD, 1'b1};  // sra x3,x1,x2
    vec[5] = '{32'h4020C1B3, 1'b0, 5'd0, 5'd0, 5'd0, 4'h0, 1'b0};  // bit30 with funct3 100
    vec[6] = '{32'h022081B3, 1'b0, 5'd0, 5'd0, 5'd0, 4'h0, 1'b0};  // mul (funct7 bit25)
    vec[7] = '{32'h80000033, 1'b0, 5'd0, 5'd0, 5'd0, 4'h0, 1'b0};  // bit31 set
    vec[8] = '{32'h0020F1B3, 1'b1, 5'd1, 5'd2, 5'd3, 4'h7, 1'b1};  // and x3,x1,x2
  end

  typedef struct {
    bit          ill;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  wa;
    logic [3:0]  op;
    bit          rw;
    logic [7:0]  pc;
    logic [15:0] cnt;
    int          lat;
    time         t;
  } exp_t;

  exp_t        q [$];
  exp_t        e_m;
  logic [7:0]  exp_pc;
  logic [15:0] exp_cnt;
  int          n_pass;
  int          n_total;
  bit          rr_d1, rr_d2, f_d1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic note_fail(input string name);
    n_total++;
    $display("FAIL %s: bound expired or unexpected output (t=%0t)", name, $time);
  endtask

  // Plays instruction memory for one fetch and queues the expected response.
  task automatic issue(input int idx, input int dly, input bit push);
    int n;
    bit held;
    exp_t e;
    n = 0;
    while (inst_req !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      note_fail("fetch_timeout");
      return;
    end
    chk("fetch_addr", inst_addr, exp_pc);
    chk("cnt_at_fetch", instr_cnt, exp_cnt);
    held = 1'b1;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      if (inst_req !== 1'b1) held = 1'b0;
    end
    if (dly > 0) chk("req_held", held, 1);
    inst_data  = vec[idx].data;
    inst_valid = 1'b1;
    if (push) begin
      e.ill = !vec[idx].legal;
      e.ra  = vec[idx].ra;
      e.rb  = vec[idx].rb;
      e.wa  = vec[idx].wa;
      e.op  = vec[idx].op;
      e.rw  = vec[idx].rw;
      // The illegal pulse appears after PC has already advanced; WB shows the old PC.
      e.pc  = vec[idx].legal ? exp_pc : exp_pc + 8'd4;
      e.cnt = exp_cnt;
      e.lat = vec[idx].legal ? 4 : 2;
      e.t   = $time;
      q.push_back(e);
    end
    exp_pc = exp_pc + 8'd4;
    if (vec[idx].legal) exp_cnt = exp_cnt + 16'd1;
    @(negedge clk);
    inst_valid = 1'b0;
    inst_data  = 32'hFFFF_FFFF;
  endtask

  // Monitor: pops an expectation whenever the DUT retires or flags an instruction.
  always @(negedge clk) begin
    if (rst_n && (wb_en || illegal)) begin
      if (q.size() == 0) begin
        note_fail("unexpected_event");
      end else begin
        e_m = q.pop_front();
        chk("event_kind", {31'd0, illegal}, {31'd0, e_m.ill});
        chk("event_pc", inst_addr, e_m.pc);
        chk("event_cnt", instr_cnt, e_m.cnt);
        chk("latency", 32'(($time - e_m.t) / 10), e_m.lat);
        chk("no_rr_f_now", {rr_en, f_en}, 0);
        if (!e_m.ill) begin
          chk("R_Addr_A", R_Addr_A, e_m.ra);
          chk("R_Addr_B", R_Addr_B, e_m.rb);
          chk("W_Addr", W_Addr, e_m.wa);
          chk("ALU_OP", ALU_OP, e_m.op);
          chk("Reg_Write", Reg_Write, e_m.rw);
          chk("f_en_prev", f_d1, 1);
          chk("rr_en_prev2", rr_d2, 1);
        end else begin
          chk("ill_no_wb", {wb_en, Reg_Write}, 0);
          chk("ill_no_rr_prev", {rr_d1, f_d1}, 0);
        end
      end
    end
    rr_d2 = rr_d1;
    rr_d1 = rr_en;
    f_d1  = f_en;
  end

  initial begin
    int n;
    n_pass = 0;
    n_total = 0;
    rr_d1 = 0; rr_d2 = 0; f_d1 = 0;
    rst_n = 1'b0;
    run = 1'b0;
    inst_valid = 1'b0;
    inst_data = 32'h0;
    exp_pc = 8'h00;
    exp_cnt = 16'h0;

    repeat (2) @(negedge clk);
    chk("rst_inst_req", inst_req, 0);
    chk("rst_inst_addr", inst_addr, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", instr_cnt, 0);
    chk("rst_fields", {R_Addr_A, R_Addr_B, W_Addr, ALU_OP}, 0);
    chk("rst_strobes", {rr_en, f_en, wb_en, Reg_Write, illegal}, 0);

    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_run", {busy, inst_req}, 0);
    run = 1'b1;

    for (int i = 0; i < 9; i++) issue(i, 0, 1'b1);
    issue(0, 3, 1'b1);

    // Drop run during EX: the instruction must still retire, then go idle.
    issue(1, 0, 1'b1);
    n = 0;
    while (f_en !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) note_fail("f_en_timeout");
    run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_req", inst_req, 0);
    // A stray inst_valid while idle must be ignored.
    inst_valid = 1'b1;
    inst_data = 32'h002081B3;
    repeat (3) @(negedge clk);
    chk("stray_valid_busy", busy, 0);
    chk("stray_valid_pc", inst_addr, exp_pc);
    chk("stray_valid_cnt", instr_cnt, exp_cnt);
    inst_valid = 1'b0;

    // Reset asserted just after entering EX aborts the instruction.
    run = 1'b1;
    issue(1, 0, 1'b0);
    n = 0;
    while (rr_en !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) note_fail("rr_en_timeout");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_f_en", f_en, 0);
    chk("arst_busy", busy, 0);
    chk("arst_req", inst_req, 0);
    chk("arst_addr", inst_addr, 8'h00);
    chk("arst_cnt", instr_cnt, 0);
    chk("arst_fields", {R_Addr_A, R_Addr_B, W_Addr, ALU_OP}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_pc = 8'h00;
    exp_cnt = 16'h0;
    issue(0, 0, 1'b1);

    // Walk PC around the 8-bit space with quick illegal instructions.
    while (exp_pc != 8'h00) issue(3, 0, 1'b1);
    issue(4, 0, 1'b1);

    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", q.size(), 0);
    chk("final_cnt", instr_cnt, exp_cnt);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instr_seq_ctrl.md
INSTR_SEQ_CTRL -- requirements
Module: instr_seq_ctrl

Interface
REQ-001 Parameter PC_W, default 8, width of program counter and inst_addr.
REQ-002 Parameter RESET_PC, default 0, PC value loaded by reset.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 run  input  1  level; high = fetch and execute instructions continuously.
REQ-006 inst_req  output  1  fetch request to instruction memory.
REQ-007 inst_addr  output  PC_W  fetch address (= PC).
REQ-008 inst_valid  input  1  memory returns inst_data this cycle.
REQ-009 inst_data  input  32  RV32 instruction word.
REQ-010 R_Addr_A  output  5  rs1 (IR[19:15]) to register-array read port A.
REQ-011 R_Addr_B  output  5  rs2 (IR[24:20]) to read port B.
REQ-012 W_Addr  output  5  rd (IR[11:7]) to write port.
REQ-013 ALU_OP  output  4  ALU operation code.
REQ-014 Reg_Write  output  1  register write enable, asserted only in WB.
REQ-015 rr_en  output  1  one-cycle strobe: latch operand registers A/B.
REQ-016 f_en  output  1  one-cycle strobe: latch ALU result F and flags FR.
REQ-017 wb_en  output  1  one-cycle strobe: write F back to register array.
REQ-018 illegal  output  1  one-cycle pulse on an undecodable instruction.
REQ-019 busy  output  1  high in every state except IDLE.
REQ-020 instr_cnt  output  16  count of retired (WB-completed) instructions.

Function
REQ-021 The FSM SHALL have states IDLE, IF, ID, RR, EX, WB; all outputs registered.
REQ-022 IDLE SHALL go to IF when run=1, else stay.
REQ-023 IF SHALL hold inst_req=1 and inst_addr=PC until inst_valid=1; on that edge IR<=inst_data, inst_req<=0, go to ID; inst_valid outside IF SHALL be ignored.
REQ-024 ID SHALL drive R_Addr_A/R_Addr_B/W_Addr from IR and ALU_OP={IR[30],IR[14:12]}, then go to RR if legal.
REQ-025 An instruction SHALL be legal only when IR[6:0]=0110011, IR[31]=0, IR[29:25]=0, and IR[30]=1 only with funct3 000 or 101.
REQ-026 Illegal in ID: illegal pulses 1 cycle, PC<=PC+4, no rr_en/f_en/wb_en/Reg_Write, instr_cnt unchanged, next state IF if run else IDLE.
REQ-027 RR SHALL assert rr_en for exactly one cycle, then EX.
REQ-028 EX SHALL assert f_en for exactly one cycle, then WB.
REQ-029 WB SHALL assert wb_en for one cycle and Reg_Write=1 only when rd!=0; PC<=PC+4; instr_cnt+1; next IF if run else IDLE.
REQ-030 Minimum latency SHALL be 5 cycles per instruction (IF with inst_valid in first cycle); strobes SHALL be mutually exclusive.
REQ-031 PC SHALL wrap modulo 2^PC_W; instr_cnt SHALL wrap 0xFFFF->0x0000.
REQ-032 Deassertion of run mid-instruction SHALL NOT abort it; it completes WB, then IDLE.
REQ-033 R_Addr_A/B, W_Addr, ALU_OP SHALL hold stable from ID until next ID.

Reset
REQ-034 rst_n=0 SHALL immediately force IDLE, PC=RESET_PC, IR=0, instr_cnt=0, and all outputs 0 (inst_addr=RESET_PC), including mid-instruction.
REQ-035 First IF after rst_n release SHALL fetch from RESET_PC.

Verification
REQ-036 run=1, inst_data=0x002081B3 valid immediately -> R_Addr_A=1, R_Addr_B=2, W_Addr=3, ALU_OP=0000; rr_en,f_en,wb_en on consecutive cycles; Reg_Write=1; PC 0->4; instr_cnt=1.
REQ-037 inst_data=0x407302B3 -> R_Addr_A=6, R_Addr_B=7, W_Addr=5, ALU_OP=1000, Reg_Write=1.
REQ-038 inst_data=0x00208033 (rd=0) -> wb_en=1, Reg_Write=0, instr_cnt increments.
REQ-039 inst_data=0x00000013 -> illegal one-cycle pulse, no strobes, PC+4, instr_cnt unchanged.
REQ-040 inst_valid delayed 3 cycles in IF -> inst_req held 3 cycles; run dropped during EX -> WB completes then IDLE, busy=0.
REQ-041 rst_n pulsed low during EX -> all outputs 0 at once, no f_en, restart fetches RESET_PC.
